// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared helpers and constants for the sequence detector
//
// Purpose: progress-width helper, default pattern constant and a symbol-slice
// helper for packed patterns (symbol i lives at bits [i*W +: W]).
package seq_pkg;

  // Upper bounds for the slice helper; a pattern is zero-extended to PAT_MAX
  // bits before slicing, and one symbol is returned in SYM_MAX bits.
  localparam int PAT_MAX = 256;
  localparam int SYM_MAX = 32;

  // Default pattern 1,2,3 with W=2: symbol 0 in the low bits.
  localparam logic [5:0] DEF_PAT_C = 6'h39;

  // Bits needed to hold a progress value in 0..len.
  function automatic int prog_w(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

  // Symbol idx of a packed pattern with w-bit symbols. Indices past the end
  // of the real pattern read the zero extension, which never matches a
  // non-idle input.
  function automatic logic [SYM_MAX-1:0] pat_sym(input logic [PAT_MAX-1:0] pat,
                                                 input int w, input int idx);
    logic [PAT_MAX-1:0] sh;
    logic [SYM_MAX-1:0] mask;
    sh   = pat >> (idx * w);
    mask = (SYM_MAX'(1) << w) - SYM_MAX'(1);
    return sh[SYM_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc pulses, sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc (count one), clr (zero, wins
// over inc), count (current value).
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - programmable streaming sequence detector
//
// Purpose: flags when LEN non-idle symbols matching the pattern register
// arrive in order; idle (0) symbols are skipped.
// Ports: clk, rst_n (async active-low), in_valid/num (symbol stream),
// clr (clear progress/ans/hit_count), pat_load/pat_data (reprogram pattern),
// ans (detection flag), progress (symbols matched), hit_count (saturating).
module seq_detector
  import seq_pkg::*;
#(
  parameter int              W       = 2,
  parameter int              LEN     = 3,
  parameter bit              STICKY  = 1'b1,
  parameter int              CNT_W   = 8,
  parameter logic [W*LEN-1:0] DEF_PAT = DEF_PAT_C
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [W-1:0]              num,
  input  logic                      clr,
  input  logic                      pat_load,
  input  logic [W*LEN-1:0]          pat_data,
  output logic                      ans,
  output logic [prog_w(LEN)-1:0]    progress,
  output logic [CNT_W-1:0]          hit_count
);

  localparam int PW = prog_w(LEN);

  logic [W*LEN-1:0]   pat_q, pat_d;
  logic [PW-1:0]      progress_q, progress_d;
  logic               ans_q, ans_d;
  logic               hit;
  logic [PAT_MAX-1:0] pat_ext;
  logic [W-1:0]       sym_cur;
  logic [W-1:0]       sym_first;

  assign pat_ext   = PAT_MAX'(pat_q);
  assign sym_cur   = W'(pat_sym(pat_ext, W, int'(progress_q)));
  assign sym_first = W'(pat_sym(pat_ext, W, 0));

  always_comb begin
    pat_d      = pat_q;
    progress_d = progress_q;
    // Pulse mode drops ans every cycle unless a new hit re-raises it.
    ans_d      = STICKY ? ans_q : 1'b0;
    hit        = 1'b0;

    if (pat_load) begin
      pat_d      = pat_data;
      progress_d = '0;
      ans_d      = 1'b0;
    end else if (clr) begin
      progress_d = '0;
      ans_d      = 1'b0;
    end else if (in_valid && (num != '0) && !(STICKY && ans_q)) begin
      // A latched sticky hit ignores the stream until clr or pat_load.
      if (num == sym_cur) begin
        if (progress_q == PW'(LEN - 1)) begin
          hit = 1'b1;
        end else begin
          progress_d = progress_q + 1'b1;
        end
      end else if (num == sym_first) begin
        // Mismatch restarts on the first symbol rather than dropping it.
        if (LEN == 1) begin
          hit = 1'b1;
        end else begin
          progress_d = PW'(1);
        end
      end else begin
        progress_d = '0;
      end

      if (hit) begin
        ans_d      = 1'b1;
        progress_d = STICKY ? PW'(LEN) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= DEF_PAT;
      progress_q <= '0;
      ans_q      <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      progress_q <= progress_d;
      ans_q      <= ans_d;
    end
  end

  // clr clears the count even when pat_load takes the rest of the edge;
  // hit is only ever raised when neither is present.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (clr),
    .count (hit_count)
  );

  assign ans      = ans_q;
  assign progress = progress_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - self-checking bench for seq_detector
module tb_seq_detector;

  localparam int W   = 2;
  localparam int LEN = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     num = '0;
  logic             clr = 1'b0;
  logic             pat_load = 1'b0;
  logic [W*LEN-1:0] pat_data = '0;

  logic       ans_s, ans_p;
  logic [1:0] prog_s, prog_p;
  logic [7:0] cnt_s;
  logic [1:0] cnt_p;

  seq_detector #(.W(W), .LEN(LEN), .STICKY(1'b1), .CNT_W(8), .DEF_PAT(6'h39)) u_sticky (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .clr(clr),
    .pat_load(pat_load), .pat_data(pat_data), .ans(ans_s), .progress(prog_s),
    .hit_count(cnt_s)
  );

  seq_detector #(.W(W), .LEN(LEN), .STICKY(1'b0), .CNT_W(2), .DEF_PAT(6'h39)) u_pulse (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .clr(clr),
    .pat_load(pat_load), .pat_data(pat_data), .ans(ans_p), .progress(prog_p),
    .hit_count(cnt_p)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: pattern as a list of symbols, per-instance matched
  // count, flag and hit total. Index 0 = sticky instance, 1 = pulse instance.
  int m_pat[LEN];
  int m_p[2];
  int m_a[2];
  int m_c[2];
  int m_max[2] = '{255, 3};

  task automatic model_set_pat(input int packed_pat);
    for (int i = 0; i < LEN; i++) m_pat[i] = (packed_pat >> (i * W)) % (1 << W);
  endtask

  task automatic model_reset();
    model_set_pat(6'h39);
    for (int m = 0; m < 2; m++) begin
      m_p[m] = 0; m_a[m] = 0; m_c[m] = 0;
    end
  endtask

  task automatic model_step(input int v, input int n, input int c, input int l, input int d);
    for (int m = 0; m < 2; m++) begin
      bit sticky;
      bit hit;
      sticky = (m == 0);
      hit = 0;
      if (!sticky) m_a[m] = 0;
      if (l != 0) begin
        m_p[m] = 0; m_a[m] = 0;
        if (c != 0) m_c[m] = 0;
      end else if (c != 0) begin
        m_p[m] = 0; m_a[m] = 0; m_c[m] = 0;
      end else if (v != 0 && n != 0 && !(sticky && m_a[m] != 0)) begin
        if (n == m_pat[m_p[m]]) begin
          m_p[m]++;
          if (m_p[m] == LEN) hit = 1;
        end else if (n == m_pat[0]) begin
          m_p[m] = 1;
          if (LEN == 1) hit = 1;
        end else begin
          m_p[m] = 0;
        end
        if (hit) begin
          m_a[m] = 1;
          if (m_c[m] < m_max[m]) m_c[m]++;
          m_p[m] = sticky ? LEN : 0;
        end
      end
    end
    if (l != 0) model_set_pat(d);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ans_s"},  int'(ans_s),  m_a[0]);
    check({tag, "_prog_s"}, int'(prog_s), m_p[0]);
    check({tag, "_cnt_s"},  int'(cnt_s),  m_c[0]);
    check({tag, "_ans_p"},  int'(ans_p),  m_a[1]);
    check({tag, "_prog_p"}, int'(prog_p), m_p[1]);
    check({tag, "_cnt_p"},  int'(cnt_p),  m_c[1]);
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input string tag, input int v, input int n,
                      input int c = 0, input int l = 0, input int d = 0);
    in_valid = v[0];
    num      = n[W-1:0];
    clr      = c[0];
    pat_load = l[0];
    pat_data = d[W*LEN-1:0];
    model_step(v, n, c, l, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic seq3(input string tag, input int a, input int b, input int c);
    step(tag, 1, a);
    step(tag, 1, b);
    step(tag, 1, c);
  endtask

  int exp_prog[5] = '{1, 2, 1, 2, 3};
  int rsym[5]     = '{1, 2, 1, 2, 3};

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Defaults
    seq3("dflt", 1, 2, 3);
    check("dflt_ans_lit", int'(ans_s), 1);
    check("dflt_prog_lit", int'(prog_s), 3);
    check("dflt_cnt_lit", int'(cnt_s), 1);
    seq3("dflt2", 1, 2, 3);
    check("dflt2_cnt_lit", int'(cnt_s), 1);

    // Idle gaps
    step("clr", 0, 0, 1);
    step("idle", 1, 1); step("idle", 1, 0); step("idle", 1, 2);
    step("idle", 1, 0); step("idle", 1, 3);
    check("idle_ans_lit", int'(ans_s), 1);

    // Restart on first symbol
    step("clr", 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step("rst1", 1, rsym[i]);
      check("restart_prog_lit", int'(prog_s), exp_prog[i]);
    end
    step("clr", 0, 0, 1);
    step("r13", 1, 1); step("r13", 1, 3);
    check("r13_prog_lit", int'(prog_s), 0);
    step("r122", 1, 1); step("r122", 1, 2); step("r122", 1, 2);
    check("r122_prog_lit", int'(prog_s), 0);
    step("inv", 1, 1); step("inv", 0, 2); step("inv", 0, 3);
    check("inv_prog_lit", int'(prog_s), 1);

    // Pulse mode back-to-back and saturation
    step("clr", 0, 0, 1);
    seq3("pulse", 1, 2, 3);
    check("pulse_ans1_lit", int'(ans_p), 1);
    seq3("pulse", 1, 2, 3);
    check("pulse_cnt2_lit", int'(cnt_p), 2);
    step("pulse_drop", 0, 0);
    check("pulse_drop_lit", int'(ans_p), 0);
    for (int h = 0; h < 3; h++) seq3("sat", 1, 2, 3);
    check("pulse_sat_lit", int'(cnt_p), 3);

    // Reprogramming
    step("ld39", 0, 0, 0, 1, 6'h39);
    step("rp", 1, 1); step("rp", 1, 2);
    step("ld1b", 0, 0, 0, 1, 6'h1B);
    check("ld_prog_lit", int'(prog_s), 0);
    check("ld_ans_lit", int'(ans_s), 0);
    check("ld_cnt_kept_lit", int'(cnt_p), 3);
    seq3("old", 1, 2, 3);
    check("old_nohit_lit", int'(ans_s), 0);
    seq3("new", 3, 2, 1);
    check("new_hit_lit", int'(ans_s), 1);

    // Priority
    step("pr_ld", 0, 0, 0, 1, 6'h39);
    step("pr_clr", 0, 0, 1);
    step("pr", 1, 1); step("pr", 1, 2);
    step("pr_clrhit", 1, 3, 1);
    check("pr_clrhit_ans_lit", int'(ans_p), 0);
    check("pr_clrhit_cnt_lit", int'(cnt_s), 0);
    seq3("pr_cnt", 1, 2, 3);
    step("pr_both", 1, 3, 1, 1, 6'h1B);
    check("pr_both_cnt_lit", int'(cnt_s), 0);
    seq3("pr_both_new", 3, 2, 1);
    check("pr_both_hit_lit", int'(ans_s), 1);

    // Asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_ans_lit", int'(ans_s), 0);
    check("arst_prog_lit", int'(prog_s), 0);
    check("arst_cnt_lit", int'(cnt_s), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq3("arst_def", 1, 2, 3);
    check("arst_defpat_lit", int'(ans_s), 1);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      int v, n, c, l, d;
      v = ($urandom_range(0, 9) < 8) ? 1 : 0;
      n = $urandom_range(0, 3);
      c = ($urandom_range(0, 39) == 0) ? 1 : 0;
      l = ($urandom_range(0, 59) == 0) ? 1 : 0;
      d = 0;
      for (int i = 0; i < LEN; i++) begin
        int s;
        s = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
        d = d | (s << (i * W));
      end
      step("rand", v, n, c, l, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised streaming sequence detector for the sequential-logic block set. It watches a W-bit symbol stream and flags when a runtime-programmable pattern of LEN non-idle symbols arrives in order; idle symbols (value 0) between pattern symbols are ignored. The block generalises the fixed three-symbol counter: symbol width, pattern length and pattern contents are configurable, and it adds input qualification, a sticky or pulse mode, a synchronous clear and a saturating hit counter.

## Interface
- W, 2: symbol width in bits.
- LEN, 3: pattern length in symbols, ≥1.
- STICKY, 1: 1 holds ans until clr/pat_load; 0 pulses ans and re-arms.
- CNT_W, 8: hit counter width.
- DEF_PAT, 6'h39: reset pattern, W*LEN bits; symbol i at [i*W +: W]; default is 1,2,3.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  num is sampled only when high.
- num  in  W  input symbol; 0 = idle.
- clr  in  1  synchronous clear of progress, ans, hit_count.
- pat_load  in  1  load pat_data into the pattern register.
- pat_data  in  W*LEN  new pattern, same packing as DEF_PAT.
- ans  out  1  detection flag, registered.
- progress  out  $clog2(LEN+1)  symbols matched so far.
- hit_count  out  CNT_W  completed matches, saturating.

## Operation
- Reset (rst_n low, asynchronous): progress=0, ans=0, hit_count=0, pattern=DEF_PAT.
- Per-edge priority: pat_load > clr > in_valid. pat_load writes the pattern, zeroes progress and ans, and keeps hit_count. clr zeroes progress, ans and hit_count. The pattern is unchanged by clr.
- Accepted symbol (in_valid=1, no pat_load/clr), with p = progress and P[i] = pattern symbol i:
  - num==0: no change.
  - num==P[p]: p+1. If p+1==LEN, this is a hit.
  - Otherwise: p = (num==P[0]) ? 1 : 0. This restarts on the first symbol. If LEN==1 and num==P[0], it is a hit.
- Hit, STICKY=1: progress=LEN, ans=1. Further symbols are ignored until clr or pat_load. hit_count increments once.
- Hit, STICKY=0: progress=0, ans=1 for exactly one cycle, and hit_count increments. Matching is non-overlapping; the next symbol is evaluated from p=0.
- hit_count saturates at 2^CNT_W−1.
- A pattern symbol of 0 can never match, so a pattern containing 0 is a configuration error. The block stays legal: it simply never advances past that position.

## Timing
- Single clock domain. All outputs are registered and change only on the rising edge, except on asynchronous reset.
- ans, progress and hit_count reflect a symbol one cycle after the edge that samples it. Latency from the final pattern symbol to ans=1 is one edge.
- STICKY=0: ans is high for exactly one clock per hit, including back-to-back hits. With LEN==1, consecutive valid P[0] symbols give a continuous high run, one hit per cycle.
- clr or pat_load in the hit cycle overrides the hit: no ans, no count.
- Reset asserted mid-sequence forces outputs to 0 immediately. The first accepted symbol is on the first edge after rst_n rises.

## Structure
- Shared package seq_pkg holds:
  - the progress-width helper;
  - the default pattern constant;
  - a symbol-slice helper for the packed pattern.
- Sub-module sat_counter (CNT_W parameter; inc, clr, count) implements hit_count.
- Match and next-progress logic are combinational in seq_detector, with a single registered state update.

## Test plan
- Defaults. Reset, then valid 1,2,3 → ans=1 after the third edge; progress=3; hit_count=1; a further 1,2,3 leaves hit_count=1.
- Idle and restart. Sequence 1,0,2,0,3 → hit. Sequence 1,2,1,2,3 → hit, with progress 1,2,1,2,3. Sequence 1,3 → progress 0. Sequence 1,2,2 → progress 0. Symbols with in_valid=0 change nothing.
- STICKY=0, CNT_W=2. Stream 1,2,3,1,2,3 → two one-cycle ans pulses, hit_count=2. After 5 hits, hit_count=3 (saturated).
- Reprogramming. pat_load with 6'h1B at progress 2 → progress 0, ans 0, hit_count kept. Then 3,2,1 → hit, while 1,2,3 → no hit.
- Priority. clr and a final matching symbol on the same edge → ans 0, hit_count 0. pat_load and clr together → pattern loaded, hit_count cleared.
- Async reset. Drop rst_n between edges while ans=1 → ans, progress and hit_count are 0 before the next edge, and the pattern reverts to 1,2,3.
